// File: rtl/cb_input_stager_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cb_pkg : shared types and block-size defaults for cb_input_stager        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package cb_pkg;

   localparam int unsigned SHORT_BYTES_DFLT = 5;
   localparam int unsigned LONG_BYTES_DFLT  = 132;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FILL    = 2'd1,
      DISCARD = 2'd2
   } wr_state_e;

   typedef struct packed {
      logic [7:0] tail;
      logic       is_long;
   } meta_t;

endpackage
`default_nettype wire

// File: rtl/cb_input_stager_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cb_input_stager_if : upstream stream + encoder read port bundle          |
// | Optional stats signals under CB_STAGER_STATS_EN.  Revision: 1.0          |
// +--------------------------------------------------------------------------+
interface cb_input_stager_if;

   logic       in_valid;
   logic [7:0] in_data;
   logic       in_last;
   logic       in_ready;
   logic       blk_ready;
   logic [7:0] tail_byte;
   logic       code_block_length;
   logic       blk_empty;
   logic [7:0] blk_data;
   logic       blk_data_rdreq;
   logic       blk_err;
`ifdef CB_STAGER_STATS_EN
   logic [15:0] blk_count;
   logic [15:0] drop_count;

   modport master (
      output in_valid, in_data, in_last, blk_data_rdreq,
      input  in_ready, blk_ready, tail_byte, code_block_length,
             blk_empty, blk_data, blk_err, blk_count, drop_count
   );

   modport slave (
      input  in_valid, in_data, in_last, blk_data_rdreq,
      output in_ready, blk_ready, tail_byte, code_block_length,
             blk_empty, blk_data, blk_err, blk_count, drop_count
   );
`else
   modport master (
      output in_valid, in_data, in_last, blk_data_rdreq,
      input  in_ready, blk_ready, tail_byte, code_block_length,
             blk_empty, blk_data, blk_err
   );

   modport slave (
      input  in_valid, in_data, in_last, blk_data_rdreq,
      output in_ready, blk_ready, tail_byte, code_block_length,
             blk_empty, blk_data, blk_err
   );
`endif

endinterface
`default_nettype wire

// File: rtl/cb_input_stager_meta_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cb_meta_fifo : 2-entry FIFO of committed-block tail/size descriptors     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cb_meta_fifo
   import cb_pkg::*;
(
   input  wire logic  clk,
   input  wire logic  reset,
   input  wire logic  push_i,
   input  wire meta_t push_data_i,
   input  wire logic  pop_i,
   output meta_t      head_o,
   output logic       empty_o,
   output logic       full_o
);

   meta_t      mem_q [2];
   logic       wr_idx_q;
   logic       rd_idx_q;
   logic [1:0] count_q;
   logic       push_ok;
   logic       pop_ok;

   assign empty_o = (count_q == 2'd0);
   assign full_o  = (count_q == 2'd2);
   assign head_o  = mem_q[rd_idx_q];
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_idx_q <= 1'b0;
         rd_idx_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_ok) begin
            mem_q[wr_idx_q] <= push_data_i;
            wr_idx_q        <= ~wr_idx_q;
         end
         if (pop_ok) begin
            rd_idx_q <= ~rd_idx_q;
         end
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/cb_input_stager.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cb_input_stager : length-checking staging buffer ahead of the TBCC       |
// | Optional blk/drop counters under CB_STAGER_STATS_EN.  Revision: 1.0      |
// +--------------------------------------------------------------------------+
module cb_input_stager
   import cb_pkg::*;
#(
   parameter int unsigned DEPTH       = 512,
   parameter int unsigned SHORT_BYTES = SHORT_BYTES_DFLT,
   parameter int unsigned LONG_BYTES  = LONG_BYTES_DFLT
)(
   input  wire logic        clk,
   input  wire logic        reset,
   cb_input_stager_if.slave bus
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(LONG_BYTES + 2);
   localparam logic [CW-1:0] C_SHORT = CW'(SHORT_BYTES);
   localparam logic [CW-1:0] C_LONG  = CW'(LONG_BYTES);

   wr_state_e       state_q, state_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   commit_ptr_q, commit_ptr_d;
   logic [AW-1:0]   rd_ptr_q;
   logic [CW-1:0]   wr_cnt_q, wr_cnt_d;
   logic [CW-1:0]   rd_cnt_q;
   logic [CW-1:0]   wr_cnt_inc;
   logic [CW-1:0]   rd_cnt_inc;
   logic [CW-1:0]   head_len;
   logic            blk_err_q, blk_err_d;
   logic [7:0]      blk_data_q;
   logic [7:0]      mem_q [DEPTH];

   logic            accept;
   logic            ram_we;
   logic            rd_en;
   logic            blk_empty;
   logic            meta_push;
   logic            meta_pop;
   logic            meta_empty;
   logic            meta_full;
   meta_t           meta_push_data;
   meta_t           meta_head;

   assign accept     = bus.in_valid && !meta_full;
   assign wr_cnt_inc = wr_cnt_q + 1'b1;
   assign blk_empty  = (rd_ptr_q == commit_ptr_q);

   assign meta_push_data.tail    = bus.in_data;
   assign meta_push_data.is_long = (wr_cnt_inc == C_LONG);

   // Write FSM: bytes land in the buffer immediately, but only become
   // readable once commit_ptr moves past them; a drop just rewinds wr_ptr.
   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      commit_ptr_d = commit_ptr_q;
      wr_cnt_d     = wr_cnt_q;
      blk_err_d    = 1'b0;
      ram_we       = 1'b0;
      meta_push    = 1'b0;
      if (accept) begin
         case (state_q)
            IDLE, FILL: begin
               ram_we   = 1'b1;
               wr_ptr_d = wr_ptr_q + 1'b1;
               wr_cnt_d = wr_cnt_inc;
               state_d  = FILL;
               if (bus.in_last) begin
                  state_d  = IDLE;
                  wr_cnt_d = '0;
                  if ((wr_cnt_inc == C_SHORT) || (wr_cnt_inc == C_LONG)) begin
                     commit_ptr_d = wr_ptr_q + 1'b1;
                     meta_push    = 1'b1;
                  end else begin
                     wr_ptr_d  = commit_ptr_q;
                     blk_err_d = 1'b1;
                  end
               end else if (wr_cnt_inc > C_LONG) begin
                  state_d   = DISCARD;
                  wr_cnt_d  = '0;
                  wr_ptr_d  = commit_ptr_q;
                  blk_err_d = 1'b1;
               end
            end
            DISCARD: begin
               if (bus.in_last) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         wr_ptr_q     <= '0;
         commit_ptr_q <= '0;
         wr_cnt_q     <= '0;
         blk_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         wr_cnt_q     <= wr_cnt_d;
         blk_err_q    <= blk_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (ram_we) begin
         mem_q[wr_ptr_q] <= bus.in_data;
      end
   end

   assign rd_en      = bus.blk_data_rdreq && !blk_empty;
   assign head_len   = meta_head.is_long ? C_LONG : C_SHORT;
   assign rd_cnt_inc = rd_cnt_q + 1'b1;
   assign meta_pop   = rd_en && (rd_cnt_inc == head_len);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_q   <= '0;
         rd_cnt_q   <= '0;
         blk_data_q <= 8'h00;
      end else if (rd_en) begin
         rd_ptr_q   <= rd_ptr_q + 1'b1;
         rd_cnt_q   <= meta_pop ? '0 : rd_cnt_inc;
         blk_data_q <= mem_q[rd_ptr_q];
      end
   end

   cb_meta_fifo u_meta_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (meta_push),
      .push_data_i (meta_push_data),
      .pop_i       (meta_pop),
      .head_o      (meta_head),
      .empty_o     (meta_empty),
      .full_o      (meta_full)
   );

   assign bus.in_ready          = !meta_full;
   assign bus.blk_ready         = !meta_empty;
   assign bus.tail_byte         = meta_head.tail;
   assign bus.code_block_length = meta_head.is_long;
   assign bus.blk_empty         = blk_empty;
   assign bus.blk_data          = blk_data_q;
   assign bus.blk_err           = blk_err_q;

`ifdef CB_STAGER_STATS_EN
   logic [15:0] blk_count_q;
   logic [15:0] drop_count_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blk_count_q  <= 16'h0000;
         drop_count_q <= 16'h0000;
      end else begin
         if (meta_push && (blk_count_q != 16'hFFFF)) begin
            blk_count_q <= blk_count_q + 16'd1;
         end
         if (blk_err_q && (drop_count_q != 16'hFFFF)) begin
            drop_count_q <= drop_count_q + 16'd1;
         end
      end
   end

   assign bus.blk_count  = blk_count_q;
   assign bus.drop_count = drop_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cb_input_stager.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cb_input_stager : directed self-checking bench for cb_input_stager    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_cb_input_stager;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   cb_input_stager_if bus ();

   cb_input_stager #(
      .DEPTH       (512),
      .SHORT_BYTES (5),
      .LONG_BYTES  (132)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic l);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = l;
      tick();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic rd(input logic [7:0] exp, input string tag);
      bus.blk_data_rdreq = 1'b1;
      tick();
      bus.blk_data_rdreq = 1'b0;
      chk(tag, 32'(bus.blk_data), 32'(exp));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"},  32'(bus.in_ready),          32'd1);
      chk({tag, "_blk_ready"}, 32'(bus.blk_ready),         32'd0);
      chk({tag, "_blk_empty"}, 32'(bus.blk_empty),         32'd1);
      chk({tag, "_blk_data"},  32'(bus.blk_data),          32'h00);
      chk({tag, "_tail"},      32'(bus.tail_byte),         32'h00);
      chk({tag, "_cbl"},       32'(bus.code_block_length), 32'd0);
      chk({tag, "_blk_err"},   32'(bus.blk_err),           32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int errs;
      int err_at;

      reset              = 1'b1;
      bus.in_valid       = 1'b0;
      bus.in_data        = 8'h00;
      bus.in_last        = 1'b0;
      bus.blk_data_rdreq = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      chk_reset_vals("rst");

      // Short block 0x11..0x15
      for (int i = 0; i < 5; i++) send(8'h11 + 8'(i), i == 4);
      chk("s_blk_ready", 32'(bus.blk_ready),         32'd1);
      chk("s_tail",      32'(bus.tail_byte),         32'h15);
      chk("s_cbl",       32'(bus.code_block_length), 32'd0);
      chk("s_blk_empty", 32'(bus.blk_empty),         32'd0);
      for (int i = 0; i < 5; i++) rd(8'h11 + 8'(i), "s_rd");
      chk("s_done_ready", 32'(bus.blk_ready), 32'd0);
      chk("s_done_empty", 32'(bus.blk_empty), 32'd1);
      rd(8'h15, "s_rd_empty_hold");

      // Long block 0x00..0x83
      for (int i = 0; i < 132; i++) send(8'(i), i == 131);
      chk("l_blk_ready", 32'(bus.blk_ready),         32'd1);
      chk("l_tail",      32'(bus.tail_byte),         32'h83);
      chk("l_cbl",       32'(bus.code_block_length), 32'd1);
      for (int i = 0; i < 132; i++) rd(8'(i), "l_rd");
      chk("l_done_ready", 32'(bus.blk_ready), 32'd0);
      chk("l_done_empty", 32'(bus.blk_empty), 32'd1);

      // 7-byte block is dropped
      for (int i = 1; i <= 7; i++) send(8'(i), i == 7);
      chk("b7_err",       32'(bus.blk_err),   32'd1);
      chk("b7_blk_ready", 32'(bus.blk_ready), 32'd0);
      chk("b7_blk_empty", 32'(bus.blk_empty), 32'd1);
      tick();
      chk("b7_err_pulse", 32'(bus.blk_err), 32'd0);
      for (int i = 0; i < 5; i++) send(8'hA1 + 8'(i), i == 4);
      chk("b7_next_tail", 32'(bus.tail_byte), 32'hA5);
      for (int i = 0; i < 5; i++) rd(8'hA1 + 8'(i), "b7_next_rd");

      // 140-byte overlong block
      errs   = 0;
      err_at = 0;
      for (int i = 1; i <= 140; i++) begin
         send(8'(i), i == 140);
         if (bus.blk_err) begin
            errs++;
            err_at = i;
         end
      end
      chk("ovl_err_count", 32'(errs),          32'd1);
      chk("ovl_err_pos",   32'(err_at),        32'd133);
      chk("ovl_blk_ready", 32'(bus.blk_ready), 32'd0);
      chk("ovl_blk_empty", 32'(bus.blk_empty), 32'd1);
      for (int i = 0; i < 5; i++) send(8'h31 + 8'(i), i == 4);
      chk("ovl_next_tail", 32'(bus.tail_byte), 32'h35);
      for (int i = 0; i < 5; i++) rd(8'h31 + 8'(i), "ovl_next_rd");

      // Two long blocks fill the meta FIFO
      for (int i = 0; i < 132; i++) send(8'(i) ^ 8'h5A, i == 131);
      chk("two_a_in_ready", 32'(bus.in_ready), 32'd1);
      for (int i = 0; i < 132; i++) send(8'(i + 32), i == 131);
      chk("two_in_ready",  32'(bus.in_ready),          32'd0);
      chk("two_blk_ready", 32'(bus.blk_ready),         32'd1);
      chk("two_tail_a",    32'(bus.tail_byte),         32'hD9);
      chk("two_cbl_a",     32'(bus.code_block_length), 32'd1);
      for (int i = 0; i < 131; i++) rd(8'(i) ^ 8'h5A, "two_rd_a");
      chk("two_pre_pop_ready", 32'(bus.in_ready),  32'd0);
      chk("two_pre_pop_tail",  32'(bus.tail_byte), 32'hD9);
      rd(8'hD9, "two_rd_a_last");
      chk("two_pop_in_ready",  32'(bus.in_ready),          32'd1);
      chk("two_tail_b",        32'(bus.tail_byte),         32'hA3);
      chk("two_cbl_b",         32'(bus.code_block_length), 32'd1);
      chk("two_b_blk_ready",   32'(bus.blk_ready),         32'd1);
      chk("two_b_blk_empty",   32'(bus.blk_empty),         32'd0);

      // Reset mid-FILL with block B still committed
      send(8'h61, 1'b0);
      send(8'h62, 1'b0);
      send(8'h63, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      chk_reset_vals("mid_rst");
      tick();
      reset = 1'b0;
      tick();
      chk_reset_vals("post_rst");
      rd(8'h00, "post_rst_rd_empty");

      for (int i = 0; i < 5; i++) send(8'h71 + 8'(i), i == 4);
      chk("post_rst_tail", 32'(bus.tail_byte), 32'h75);
      for (int i = 0; i < 5; i++) rd(8'h71 + 8'(i), "post_rst_rd");
      chk("post_rst_empty", 32'(bus.blk_empty), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cb_input_stager.md
# cb_input_stager

Staging buffer directly upstream of the tail-biting convolutional encoder. It accepts code-block bytes from the segmentation/CRC stage on a valid/ready stream and checks each block's length. Only complete, valid blocks are exposed on the encoder's FIFO-style read port, together with each block's tail byte and size flag. Malformed blocks are dropped before the encoder can see any of their bytes.

## Interface
Parameters:
- DEPTH, 512 — data buffer depth in bytes; power of two, ≥ 3*LONG_BYTES.
- SHORT_BYTES, 5 — short block size in bytes (40 bits).
- LONG_BYTES, 132 — long block size in bytes (1056 bits).

Ports:
- clk  in  1  — single clock, rising edge.
- reset  in  1  — asynchronous, active-high.
- in_valid  in  1  — upstream byte valid.
- in_data  in  8  — upstream byte, MSB = first bit in time.
- in_last  in  1  — marks final byte of a block.
- in_ready  out  1  — stager can accept a byte.
- blk_ready  out  1  — at least one committed block is pending.
- tail_byte  out  8  — last byte of the head block; valid while blk_ready.
- code_block_length  out  1  — head block size: 0 = SHORT_BYTES, 1 = LONG_BYTES; valid while blk_ready.
- blk_empty  out  1  — no committed bytes remain to read.
- blk_data  out  8  — read data, registered.
- blk_data_rdreq  in  1  — encoder read request.
- blk_err  out  1  — one-cycle pulse when a block is dropped.

## Operation
- Write FSM has three states, IDLE, FILL and DISCARD. Reset enters IDLE.
- A byte is accepted on a cycle with in_valid && in_ready.
- Each accepted byte is written at wr_ptr, which then increments. wr_cnt counts bytes in the current block.
- IDLE → FILL on the first accepted byte without in_last.
- FILL ends on an accepted byte with in_last:
  - Total count equal to SHORT_BYTES or LONG_BYTES: commit. commit_ptr ← wr_ptr+1. Push {in_data, size flag} into the meta FIFO. Return to IDLE.
  - Any other count: drop. wr_ptr ← commit_ptr. Pulse blk_err. Return to IDLE.
- Overlong block: if the count would exceed LONG_BYTES without in_last, rewind wr_ptr ← commit_ptr, pulse blk_err and enter DISCARD.
- DISCARD accepts and drops bytes until an accepted in_last, then returns to IDLE. No second blk_err.
- A single byte with in_last in IDLE has length 1 and is always dropped.
- Meta FIFO holds 2 entries. in_ready = !meta_full. Given the DEPTH constraint, the data buffer cannot overflow.
- blk_empty = (rd_ptr == commit_ptr). Uncommitted bytes are never readable.
- Read side: blk_data_rdreq with !blk_empty reads at rd_ptr, then rd_ptr and rd_cnt increment. blk_data_rdreq while blk_empty is ignored; blk_data holds.
- When the read consumes the head block's final byte (rd_cnt reaches its length), the meta FIFO pops and rd_cnt ← 0.
- blk_ready = meta FIFO non-empty. tail_byte and code_block_length show the meta FIFO head.
- Pointer arithmetic is modulo DEPTH, log2(DEPTH) bits; wrap is natural.

## Timing
- Reset values: in_ready 1, blk_ready 0, blk_empty 1, blk_data 0x00, tail_byte 0x00, code_block_length 0, blk_err 0. All pointers, counters and the meta FIFO are cleared.
- Commit latency: on the edge accepting a valid in_last byte, blk_ready and !blk_empty take effect, so both are visible in the following cycle.
- Read latency: blk_data is valid in the cycle after the edge that sampled blk_data_rdreq.
- Meta pop and blk_ready deassertion (if no second block) are effective at the edge that reads the final byte.
- Simultaneous commit and pop in one cycle: meta count is unchanged. tail_byte advances to the next head.
- blk_err is asserted in the cycle after the offending accepted byte.
- Reset mid-block discards the partial block and all committed blocks.

## Configuration
- CB_STAGER_STATS_EN defined: adds outputs blk_count[15:0] and drop_count[15:0]. Both reset to 0. They increment on each commit and on each blk_err respectively, and saturate at 0xFFFF.
- CB_STAGER_STATS_EN undefined: these ports and their counters do not exist.

## Structure
- Package cb_pkg holds:
  - the SHORT_BYTES and LONG_BYTES defaults;
  - the write-state enum {IDLE, FILL, DISCARD};
  - the meta entry typedef {tail[7:0], is_long}.
- Sub-module cb_meta_fifo is a 2-entry synchronous FIFO of meta entries with push, pop, head, empty and full. Simultaneous push and pop are legal.
- The data buffer is an inferred single-clock RAM with registered read.

## Test plan
- Stream 5 bytes 0x11..0x15 with in_last on 0x15 → blk_ready=1 next cycle, tail_byte=0x15, code_block_length=0. Five reads return 0x11..0x15. blk_ready=0 and blk_empty=1 after the fifth read.
- Stream a 132-byte block, bytes 0x00..0x83 → code_block_length=1, tail_byte=0x83. Reads return the bytes in order.
- Stream 7 bytes with in_last → blk_err pulse, blk_ready stays 0, blk_empty stays 1. A following valid 5-byte block reads back correctly.
- Stream 140 bytes with in_last on the last → one blk_err after byte 133, the rest discarded. The next valid block is unaffected.
- Commit two long blocks without reading → in_ready=0. One read of the first block's final byte → in_ready=1 next cycle, and tail_byte switches to the second block's tail.
- Assert reset mid-FILL with one committed block → all outputs return to reset values, and the committed block is gone.
